aes_key_schedule_seq: RTL
=========================

// Module: aes_key_schedule_seq
// PURPOSE
//  Sequential AES key expander for AES-128, AES-192 and AES-256, selected per job by key_len.
//  Generates one 32-bit schedule word per clock into an internal 60x32 word buffer.
//  Serves 128-bit round keys in encryption order or decryption (reversed) order.
//  Sits between the key-load interface and the round-datapath cores. Uses four shared sbox instances.
// PARAMETERS
//  MAX_NK  8  largest supported Nk: 4 = AES-128 only; 6 adds AES-192; 8 adds AES-256.
//  RD_LAT  1  read latency in cycles: 1 or 2 (2 adds an output register stage).
// PORTS
//  clk       in   1    clock; all logic on the rising edge
//  rst_n     in   1    synchronous reset, active low
//  start     in   1    request an expansion; accepted when start && ready
//  key_len   in   2    00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = illegal
//  key_in    in   256  cipher key, MSB-aligned: w0 = key_in[255:224]; unused LSBs are ignored
//  ready     out  1    high only in IDLE
//  busy      out  1    high in LOAD and EXPAND
//  done      out  1    one-cycle pulse when the schedule is complete
//  cfg_err   out  1    one-cycle pulse when a start is rejected
//  keys_vld  out  1    buffer holds a complete schedule
//  nr        out  4    round count of the held schedule: 10, 12 or 14; 0 when !keys_vld
//  rd_en     in   1    read strobe
//  rd_round  in   4    round index r
//  rd_dir    in   1    0 = key for round r; 1 = key for round Nr-r (decryption order)
//  rd_key    out  128  round key, {w[4k],w[4k+1],w[4k+2],w[4k+3]}
//  rd_vld    out  1    rd_key/rd_err valid, RD_LAT cycles after rd_en
//  rd_err    out  1    read rejected; rd_key is 0
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge):
//   - state -> IDLE; ready=1.
//   - busy, done, cfg_err, keys_vld, rd_vld, rd_err = 0; nr = 0; rd_key = 0.
//   - Buffer contents are don't-care.
//   - Applies mid-expansion: the job is abandoned and no done pulse follows.
//  FSM: IDLE -> LOAD -> EXPAND -> DONE -> IDLE.
//   - IDLE: on start && ready with a legal key_len and Nk <= MAX_NK:
//     latch key and mode, clear keys_vld, go to LOAD.
//     Otherwise the start is ignored and cfg_err pulses for one cycle.
//   - LOAD (1 cycle): write w[0..Nk-1] from key_in; load the rcon register with 8'h01.
//   - EXPAND: write w[i] for i = Nk .. 4*(Nr+1)-1, one word per cycle:
//     40 cycles (AES-128), 46 (AES-192), 52 (AES-256).
//   - DONE (1 cycle): done=1, keys_vld=1, nr set; next state IDLE.
//  Word rule: t = w[i-1].
//   - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0};
//     then rcon <= xtime(rcon) (rcon 0x80 -> 0x1B).
//   - Else if Nk == 8 and i mod Nk == 4: t = SubWord(t).
//   - w[i] = w[i-Nk] ^ t.
//   - Track the mod-Nk phase with a counter; no divider.
//  Latency: start accepted in cycle 0 -> done in cycle 2+Ngen (42 / 48 / 54).
//  Ignored inputs:
//   - start while busy or in DONE: ignored, no queuing, no cfg_err.
//   - key_in and key_len changes after acceptance: no effect.
//  Reads:
//   - Sampled on rd_en in any state.
//   - Index k = rd_dir ? nr - rd_round : rd_round.
//   - Error case: !keys_vld or rd_round > nr -> rd_err=1 and rd_key=0.
//   - Otherwise rd_key = round key k and rd_err=0.
//   - rd_vld follows rd_en by exactly RD_LAT cycles; back-to-back reads give one result per cycle.
//   - A read sampled in the same cycle as an accepted start sees keys_vld=1 (old schedule).
//   - From the next cycle on, reads return rd_err until the new done.
// TESTING
//  1. AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
//     done in cycle 42; w[4]=a0fafe17; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2. AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//     done in cycle 48; w[6]=fe0c91f7; round 12 = e98ba06f448c773c8ecc720401002202.
//  3. AES-256, key 603deb10...0914dff4 (FIPS-197 A.3):
//     done in cycle 54; w[8]=9ba35411; round 14 = fe4890d1e6188d0b046df344706c631e.
//     With rd_dir=1 and rd_round=0, rd_key equals that same round-14 value.
//  4. key_len=11, or key_len=10 with MAX_NK=6:
//     cfg_err pulses, ready stays 1, keys_vld unchanged.
//     rd_round=15 after a valid AES-128 job -> rd_err=1, rd_key=0.
//  5. rst_n low at EXPAND cycle 20, then a new AES-128 start:
//     no done from the first job; keys_vld=0; second job matches scenario 1 exactly.
//  6. start pulsed during EXPAND -> ignored.
//     rd_en held every cycle through a job: rd_err=1 until done, then valid keys
//     with rd_vld at RD_LAT=1 and RD_LAT=2.

Source files
------------

// File: rtl/aes_key_schedule_seq_if.sv
// AES key schedule job/read bus.
// Master drives jobs and reads; slave is the expander.
interface aes_key_schedule_seq_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic         keys_vld;
  logic [3:0]   nr;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_dir;
  logic [127:0] rd_key;
  logic         rd_vld;
  logic         rd_err;

  modport master (
    output start, key_len, key_in,
    output rd_en, rd_round, rd_dir,
    input  ready, busy, done, cfg_err,
    input  keys_vld, nr,
    input  rd_key, rd_vld, rd_err
  );

  modport slave (
    input  start, key_len, key_in,
    input  rd_en, rd_round, rd_dir,
    output ready, busy, done, cfg_err,
    output keys_vld, nr,
    output rd_key, rd_vld, rd_err
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expander.
// One schedule word per clock; round keys served fwd or reversed.
module aes_key_schedule_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] v;
    p = 8'h00;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ v;
      v = v[7] ? ({v[6:0], 1'b0} ^ 8'h1b)
               : {v[6:0], 1'b0};
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15;
  logic [7:0] x30, x31, x62, x63;
  logic [7:0] x126, x127, inv;

  // inverse as a^254 by addition chain, then affine map
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, a);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, a);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, a);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, a);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, a);
    inv  = gmul(x127, x127);
    s = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end
endmodule

module aes_key_schedule_seq #(
  parameter int MAX_NK = 8,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  aes_key_schedule_seq_if.slave bus
);
  localparam int NW = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAXK = 4'(MAX_NK);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_EXP, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]       w [NW];
  logic [7:0][31:0]  key_q;
  logic [3:0]        nk_q;
  logic [3:0]        nr_q;
  logic              vld_q;
  logic              cfg_q;
  logic [5:0]        idx;
  logic [2:0]        ph;
  logic [7:0]        rcon;

  logic [3:0]  nk_req;
  logic        legal;
  logic        last;
  logic [5:0]  last_idx;
  logic [31:0] wprev, wback, sub_in, sub_out;
  logic [31:0] t, wnew;

  logic         rerr;
  logic [3:0]   rk;
  logic [5:0]   rbase;
  logic [127:0] rkey;

  logic         r1_vld, r1_err;
  logic [127:0] r1_key;

  function automatic logic [7:0] xtime(
    input logic [7:0] v
  );
    return v[7] ? ({v[6:0], 1'b0} ^ 8'h1b)
                : {v[6:0], 1'b0};
  endfunction

  assign nk_req = 4'd4 + {1'b0, bus.key_len, 1'b0};
  assign legal  = (bus.key_len != 2'b11)
               && (nk_req <= MAXK);

  assign last_idx = {nk_q, 2'b00} + 6'd27;
  assign last     = (idx == last_idx);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.start && legal) state_nx = S_LOAD;
      S_LOAD: state_nx = S_EXP;
      S_EXP:  if (last) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.ready = (state == S_IDLE);
    bus.busy  = (state == S_LOAD) || (state == S_EXP);
    bus.done  = (state == S_DONE);
  end

  assign bus.cfg_err  = cfg_q;
  assign bus.keys_vld = vld_q;
  assign bus.nr       = nr_q;

  assign wprev  = w[idx - 6'd1];
  assign wback  = w[idx - {2'b00, nk_q}];
  assign sub_in = (ph == 3'd0)
                ? {wprev[23:0], wprev[31:24]}
                : wprev;

  aes_key_schedule_sbox u_sb0 (.a(sub_in[31:24]), .s(sub_out[31:24]));
  aes_key_schedule_sbox u_sb1 (.a(sub_in[23:16]), .s(sub_out[23:16]));
  aes_key_schedule_sbox u_sb2 (.a(sub_in[15:8]),  .s(sub_out[15:8]));
  aes_key_schedule_sbox u_sb3 (.a(sub_in[7:0]),   .s(sub_out[7:0]));

  // next schedule word from the mod-Nk phase
  always_comb begin
    t = wprev;
    if (ph == 3'd0)
      t = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && ph == 3'd4)
      t = sub_out;
    wnew = wback ^ t;
  end

  // job control: latch, phase/rcon tracking, status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
      nk_q  <= 4'd4;
      nr_q  <= 4'd0;
      vld_q <= 1'b0;
      cfg_q <= 1'b0;
      idx   <= 6'd0;
      ph    <= 3'd0;
      rcon  <= 8'h00;
    end else begin
      cfg_q <= bus.start && (state == S_IDLE) && !legal;
      if (bus.start && (state == S_IDLE) && legal) begin
        key_q <= bus.key_in;
        nk_q  <= nk_req;
        vld_q <= 1'b0;
        nr_q  <= 4'd0;
      end
      if (state == S_LOAD) begin
        rcon <= 8'h01;
        idx  <= {2'b00, nk_q};
        ph   <= 3'd0;
      end
      if (state == S_EXP) begin
        idx <= idx + 6'd1;
        ph  <= (ph == 3'(nk_q - 4'd1)) ? 3'd0 : ph + 3'd1;
        if (ph == 3'd0) rcon <= xtime(rcon);
        if (last) begin
          vld_q <= 1'b1;
          nr_q  <= nk_q + 4'd6;
        end
      end
    end
  end

  // schedule buffer: key words on LOAD, one word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      for (int j = 0; j < 8; j++)
        if (4'(j) < nk_q) w[6'(j)] <= key_q[3'(7 - j)];
    end else if (state == S_EXP) begin
      w[idx] <= wnew;
    end
  end

  // read address and error decode
  always_comb begin
    rerr  = !vld_q || (bus.rd_round > nr_q);
    rk    = bus.rd_dir ? nr_q - bus.rd_round : bus.rd_round;
    rbase = {rk, 2'b00};
    rkey  = '0;
    if (!rerr)
      rkey = {w[rbase], w[rbase + 6'd1],
              w[rbase + 6'd2], w[rbase + 6'd3]};
  end

  // first read stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_vld <= 1'b0;
      r1_err <= 1'b0;
      r1_key <= '0;
    end else begin
      r1_vld <= bus.rd_en;
      r1_err <= bus.rd_en && rerr;
      r1_key <= bus.rd_en ? rkey : '0;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic         r2_vld, r2_err;
    logic [127:0] r2_key;

    // optional output register stage
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r2_vld <= 1'b0;
        r2_err <= 1'b0;
        r2_key <= '0;
      end else begin
        r2_vld <= r1_vld;
        r2_err <= r1_err;
        r2_key <= r1_key;
      end
    end

    assign bus.rd_vld = r2_vld;
    assign bus.rd_err = r2_err;
    assign bus.rd_key = r2_key;
  end else begin : g_lat1
    assign bus.rd_vld = r1_vld;
    assign bus.rd_err = r1_err;
    assign bus.rd_key = r1_key;
  end
endmodule
